// File: rtl/mux_pkg.sv
// Shared types and constants for the arbitrated N:1 output mux.
// Arbitration modes and the channel-index width helper live here.
package mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } arb_mode_e;

  localparam int CNT_W = 16;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational N-way arbiter: round-robin from a start pointer, or fixed lowest-index priority.
// Produces both a one-hot grant and its encoded index.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = MODE_RR,
  localparam int       SW   = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [SW-1:0] gnt_idx,
  output logic          any_gnt
);

  always_comb begin
    int start;
    int idx;
    start = int'(ptr);
    // Fixed priority scans from 0; an unreachable pointer falls back to 0 as well.
    if (MODE == MODE_FIXED || start >= N) start = 0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!any_gnt && req[idx]) begin
        any_gnt = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt_onehot[gi] = any_gnt && (gnt_idx == SW'(gi));
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-input valid/ready mux with internal arbitration and a single registered output beat.
// The output register reloads whenever it is empty or being drained, giving one beat per cycle.
module arb_mux_n
  import mux_pkg::*;
#(
  parameter int        N    = 4,
  parameter int        W    = 16,
  parameter arb_mode_e MODE = MODE_RR,
  localparam int       SW   = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grant_cnt
);

  logic [W-1:0]     out_data_reg;
  logic [SW-1:0]    out_sel_reg;
  logic             out_valid_reg;
  logic [SW-1:0]    ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [N-1:0]     gnt_onehot;
  logic [SW-1:0]    gnt_idx;
  logic             any_gnt;
  logic             load;
  logic             take;
  logic [W-1:0]     sel_data;

  rr_arbiter_n #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req        (in_valid),
    .ptr        (ptr_reg),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_gnt    (any_gnt)
  );

  assign load = !out_valid_reg || out_ready;

  // Ready is also gated by rst_n so nothing is offered while the block is held in reset.
  assign in_ready = (load && rst_n) ? gnt_onehot : '0;
  assign take     = |in_ready;

  always_comb begin
    sel_data = in_data[int'(gnt_idx)*W +: W];
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (MODE == MODE_RR && take) begin
      ptr_next = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (take && cnt_reg != '1) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
    end else begin
      if (take) begin
        out_data_reg  <= sel_data;
        out_sel_reg   <= gnt_idx;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;
  assign grant_cnt = cnt_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: round-robin, fixed priority, backpressure, reset and saturation.
// Three instances cover N=4 RR, N=4 fixed and N=3 RR.
module tb_arb_mux_n;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=4 round-robin
  logic [63:0] a_data;
  logic [3:0]  a_valid, a_ready;
  logic [15:0] a_odata, a_cnt;
  logic [1:0]  a_sel;
  logic        a_ov, a_oready;
  // N=4 fixed priority
  logic [63:0] b_data;
  logic [3:0]  b_valid, b_ready;
  logic [15:0] b_odata, b_cnt;
  logic [1:0]  b_sel;
  logic        b_ov, b_oready;
  // N=3 round-robin, 8-bit data
  logic [23:0] c_data;
  logic [2:0]  c_valid, c_ready;
  logic [7:0]  c_odata;
  logic [15:0] c_cnt;
  logic [1:0]  c_sel;
  logic        c_ov, c_oready;

  arb_mux_n #(.N(4), .W(16), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_sel(a_sel), .out_valid(a_ov), .out_ready(a_oready), .grant_cnt(a_cnt)
  );

  arb_mux_n #(.N(4), .W(16), .MODE(MODE_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_sel(b_sel), .out_valid(b_ov), .out_ready(b_oready), .grant_cnt(b_cnt)
  );

  arb_mux_n #(.N(3), .W(8), .MODE(MODE_RR)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_data(c_odata), .out_sel(c_sel), .out_valid(c_ov), .out_ready(c_oready), .grant_cnt(c_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int delivered;
    int accepted;
    int rr_seq[7];
    logic [3:0] one;

    a_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    a_valid  = 4'hF;
    a_oready = 1'b1;
    b_data   = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    b_valid  = 4'h0;
    b_oready = 1'b1;
    c_data   = {8'hC2, 8'hC1, 8'hC0};
    c_valid  = 3'b000;
    c_oready = 1'b1;
    one      = 4'b0001;

    // Reset state while requests are pending
    #2;
    chk("rst_valid", 32'(a_ov), 32'h0);
    chk("rst_data",  32'(a_odata), 32'h0);
    chk("rst_sel",   32'(a_sel), 32'h0);
    chk("rst_cnt",   32'(a_cnt), 32'h0);
    chk("rst_ready", 32'(a_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rr_first_rdy", 32'(a_ready), 32'h1);

    // Round-robin rotation with all channels requesting
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_sel",   32'(a_sel), 32'(k % 4));
      chk("rr_data",  32'(a_odata), 32'(16'hA000 + k % 4));
      chk("rr_cnt",   32'(a_cnt), 32'(k + 1));
      chk("rr_valid", 32'(a_ov), 32'h1);
      chk("rr_rdy",   32'(a_ready), 32'(one << ((k + 1) % 4)));
    end

    // Backpressure: everything frozen for 5 cycles
    a_oready = 1'b0;
    #1;
    chk("bp_rdy0", 32'(a_ready), 32'h0);
    repeat (5) begin
      step();
      chk("bp_sel",   32'(a_sel), 32'h3);
      chk("bp_data",  32'(a_odata), 32'hA003);
      chk("bp_valid", 32'(a_ov), 32'h1);
      chk("bp_cnt",   32'(a_cnt), 32'd8);
      chk("bp_rdy",   32'(a_ready), 32'h0);
    end
    a_oready = 1'b1;
    #1;
    chk("bp_resume_rdy", 32'(a_ready), 32'h1);
    step();
    chk("bp_resume_sel", 32'(a_sel), 32'h0);
    chk("bp_resume_cnt", 32'(a_cnt), 32'd9);
    step();
    chk("bp_next_sel",  32'(a_sel), 32'h1);
    chk("bp_next_data", 32'(a_odata), 32'hA001);
    chk("bp_next_cnt",  32'(a_cnt), 32'd10);

    // Asynchronous reset mid-stream with a held beat
    a_oready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_ov), 32'h0);
    chk("arst_data",  32'(a_odata), 32'h0);
    chk("arst_sel",   32'(a_sel), 32'h0);
    chk("arst_cnt",   32'(a_cnt), 32'h0);
    chk("arst_rdy",   32'(a_ready), 32'h0);
    step();
    chk("arst_hold_valid", 32'(a_ov), 32'h0);
    rst_n    = 1'b1;
    a_oready = 1'b1;
    #1;
    chk("arst_rel_rdy", 32'(a_ready), 32'h1);
    step();
    chk("arst_first_sel",  32'(a_sel), 32'h0);
    chk("arst_first_data", 32'(a_odata), 32'hA000);
    chk("arst_first_cnt",  32'(a_cnt), 32'h1);

    // Pass-through: single requester (channel 2), out_ready toggling
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    a_valid   = 4'b0100;
    delivered = 0;
    accepted  = 0;
    for (int c = 0; c < 10; c++) begin
      a_oready = (c % 2 == 0);
      #1;
      if (a_ov && a_oready) begin
        delivered++;
        chk("pt_sel", 32'(a_sel), 32'h2);
      end
      chk("pt_rdy", 32'(a_ready), (c % 2 == 0) ? 32'h4 : 32'h0);
      if (a_ready[2]) accepted++;
      step();
    end
    chk("pt_cnt",   32'(a_cnt), 32'd5);
    chk("pt_deliv", 32'(delivered), 32'd4);
    chk("pt_acc",   32'(accepted), 32'(a_cnt));

    // Fixed priority: channel 1 starves channel 3
    b_valid = 4'b1010;
    #1;
    chk("fx_rdy", 32'(b_ready), 32'h2);
    repeat (3) begin
      step();
      chk("fx_sel",  32'(b_sel), 32'h1);
      chk("fx_data", 32'(b_odata), 32'hB001);
      chk("fx_rdy_hold", 32'(b_ready), 32'h2);
    end
    b_valid = 4'b1000;
    #1;
    chk("fx_rdy3", 32'(b_ready), 32'h8);
    step();
    chk("fx_sel3",  32'(b_sel), 32'h3);
    chk("fx_data3", 32'(b_odata), 32'hB003);
    chk("fx_cnt",   32'(b_cnt), 32'd4);

    // N=3 round-robin wrap 2->0, then a sparse request pattern
    c_valid = 3'b111;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("n3_sel",  32'(c_sel), 32'(k % 3));
      chk("n3_data", 32'(c_odata), 32'(8'hC0 + k % 3));
    end
    c_valid   = 3'b101;
    rr_seq[0] = 2;
    rr_seq[1] = 0;
    rr_seq[2] = 2;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("n3_sparse_sel", 32'(c_sel), 32'(rr_seq[k]));
    end
    chk("n3_cnt", 32'(c_cnt), 32'd10);

    // Counter saturation after 65540 accepted beats
    a_valid  = 4'hF;
    a_oready = 1'b1;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", 32'(a_cnt), 32'd65534);
    step();
    chk("sat_hit", 32'(a_cnt), 32'hFFFF);
    repeat (5) step();
    chk("sat_hold", 32'(a_cnt), 32'hFFFF);
    chk("sat_sel",  32'(a_sel), 32'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised N-input, W-bit multiplexer with valid/ready handshakes, a registered output stage and built-in channel arbitration.
- Generalises the 2:1 combinational datapath mux. Channel selection is computed internally (round-robin or fixed priority) rather than driven from a select line.
- Sits between multiple datapath producers (register-file read ports, ALU result sources) and a single consumer bus.

Parameters:
- N, 4, number of input channels (2..16).
- W, 16, data width per channel (1..64).
- MODE, MODE_RR, arbitration mode from mux_pkg: MODE_RR = round-robin, MODE_FIXED = lowest index wins.
- SW, $clog2(N), width of channel index (derived, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  N x W  packed per-channel data; channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept; one-hot or zero.
- out_data  out  W  registered selected data.
- out_sel  out  SW  registered index of the channel that produced out_data.
- out_valid  out  1  out_data/out_sel hold a beat.
- out_ready  in  1  consumer accepts the beat.
- grant_cnt  out  16  count of beats accepted, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, grant_cnt=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst_n is low.
- Load enable: load = !out_valid || out_ready. This allows single-register throughput of 1 beat/cycle with no bubble.
- Grant g is combinational from in_valid and ptr:
  - MODE_RR: g = first i with in_valid[i], scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
  - MODE_FIXED: g = lowest i with in_valid[i]; ptr is unused and stays 0.
- in_ready[i] = load && in_valid[i] && (i==g). No other channel sees ready.
  - in_ready never depends on in_data.
  - A channel's in_valid must not depend on its in_ready.
- Transfer-in (any in_ready bit high) at clock edge:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - MODE_RR: ptr <= (g==N-1) ? 0 : g+1.
  - grant_cnt <= grant_cnt+1 unless it is 16'hFFFF, in which case it holds.
- Transfer-out (out_valid && out_ready) with no transfer-in: out_valid <= 0; out_data and out_sel hold their last value.
- Stall (out_valid && !out_ready): out_data, out_sel, out_valid and ptr all hold; in_ready=0.
- Latency: 1 cycle from in_valid&in_ready to out_valid.
- Simultaneous transfer-out and transfer-in in the same cycle: the new beat replaces the old one and out_valid stays 1.
- No requests (in_valid=0) while loadable: ptr holds, no count change.
- Single requester: that channel gets every cycle in both modes.
- Ptr wrap: after granting N-1, ptr returns to 0.
- Reset mid-operation:
  - Any held beat is discarded and not delivered.
  - ptr returns to 0.
  - Outputs clear asynchronously, without waiting for a clk edge.
- N not a power of 2: ptr values >= N are unreachable. Out-of-range ptr is treated as 0 (defensive).

Decomposition:
- mux_pkg:
  - typedef enum {MODE_RR, MODE_FIXED} arb_mode_e.
  - localparam CNT_W=16.
  - function automatic int idx_w(int n) returning max(1,$clog2(n)).
- Sub-module rr_arbiter_n:
  - Parameters N and MODE.
  - Inputs: req[N], ptr.
  - Outputs: gnt_onehot[N], gnt_idx, any_gnt.
  - Purely combinational.
  - arb_mux_n owns the pointer register, the output register and the counter.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel and grant_cnt go to 0 immediately; in_ready=0; first beat after release comes from channel 0 if it is valid.
- RR fairness: N=4, W=16, all in_valid=1, in_data[i]=16'hA000+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1...; out_data 16'hA000..16'hA003 repeating; grant_cnt increments by 1 each cycle.
- Fixed priority: MODE_FIXED, in_valid=4'b1010 -> only channel 1 is granted each cycle; channel 3 is starved until in_valid[1] drops, then out_sel=3.
- Backpressure: out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data and out_sel frozen, in_ready=0, ptr frozen; on out_ready=1, the next grant continues the rotation with no beat lost or duplicated.
- Pass-through: alternate out_ready 1/0 with in_valid=4'b0100 -> every delivered beat has out_sel=2; the scoreboard count equals grant_cnt.
- Saturation / wrap: preload by running 65 540 transfers -> grant_cnt holds at 16'hFFFF; run N=3 RR -> ptr wraps 2->0 and out_sel never reaches 3.
